// File: rtl/rf_ctx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_ctx_pkg
// Purpose  : shared op/state encodings and default indices for reg_file_ctx
// Revision : 1.0
// ============================================================================
package rf_ctx_pkg;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_WR     = 3'd1,
      OP_WR_ACC = 3'd2,
      OP_A2R    = 3'd3,
      OP_R2A    = 3'd4,
      OP_SWAP   = 3'd5
   } rf_op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAVE    = 2'd1,
      ST_RESTORE = 2'd2,
      ST_DONE    = 2'd3
   } rf_state_e;

   localparam int c_DEF_WIDTH    = 8;
   localparam int c_DEF_DEPTH    = 16;
   localparam int c_DEF_ZERO_IDX = 0;
   localparam int c_DEF_MEM_IDX  = 1;
   localparam int c_DEF_ACC_IDX  = 2;

endpackage
`default_nettype wire

// File: rtl/rf_ctx_bank.sv
`default_nettype none
// ============================================================================
// Module   : rf_ctx_bank
// Purpose  : WIDTH x DEPTH register array, two masked write ports, NRD reads
// Revision : 1.0
// ============================================================================
module rf_ctx_bank #(
   parameter  int WIDTH    = 8,
   parameter  int DEPTH    = 16,
   parameter  int ZERO_IDX = 0,
   parameter  int NRD      = 2,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_a_we,
   input  logic [AW-1:0]    i_a_addr,
   input  logic [WIDTH-1:0] i_a_data,
   input  logic             i_b_we,
   input  logic [AW-1:0]    i_b_addr,
   input  logic [WIDTH-1:0] i_b_data,
   input  logic [AW-1:0]    i_raddr [NRD],
   output logic [WIDTH-1:0] o_rdata [NRD]
);

   localparam logic [AW-1:0] c_ZERO = AW'(ZERO_IDX);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Port B is applied last so it wins a same-address collision (SWAP on acc).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_a_we && (i_a_addr != c_ZERO)) begin
            r_mem[i_a_addr] <= i_a_data;
         end
         if (i_b_we && (i_b_addr != c_ZERO)) begin
            r_mem[i_b_addr] <= i_b_data;
         end
      end
   end

   generate
      for (genvar g = 0; g < NRD; g++) begin : g_rd
         assign o_rdata[g] = (i_raddr[g] == c_ZERO) ? '0 : r_mem[i_raddr[g]];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_file_ctx.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_ctx
// Purpose  : accumulator register file with shadow bank context save/restore
// Revision : 1.0
// ============================================================================
module reg_file_ctx
   import rf_ctx_pkg::*;
#(
   parameter  int WIDTH    = c_DEF_WIDTH,
   parameter  int DEPTH    = c_DEF_DEPTH,
   parameter  int ZERO_IDX = c_DEF_ZERO_IDX,
   parameter  int MEM_IDX  = c_DEF_MEM_IDX,
   parameter  int ACC_IDX  = c_DEF_ACC_IDX,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  rf_op_e           op,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr1,
   input  logic [AW-1:0]    raddr2,
   input  logic             save_req,
   input  logic             restore_req,
   output logic [WIDTH-1:0] regf_out1,
   output logic [WIDTH-1:0] regf_out2,
   output logic [WIDTH-1:0] acc_out,
   output logic             busy,
   output logic             done,
   output logic             op_drop
);

   localparam logic [AW-1:0] c_ACC  = AW'(ACC_IDX);
   localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

   generate
      if ((MEM_IDX == ZERO_IDX) || (MEM_IDX == ACC_IDX) || (ZERO_IDX == ACC_IDX)) begin : g_bad_idx
         $error("reg_file_ctx: ZERO_IDX, MEM_IDX and ACC_IDX must be distinct");
      end
   endgenerate

   rf_state_e        r_state, w_state_nxt;
   logic [AW-1:0]    r_idx, w_idx_nxt;
   logic             w_busy;

   logic [AW-1:0]    w_lv_raddr [4];
   logic [WIDTH-1:0] w_lv_rd    [4];
   logic [AW-1:0]    w_sh_raddr [1];
   logic [WIDTH-1:0] w_sh_rd    [1];

   logic             w_a_we, w_b_we;
   logic [AW-1:0]    w_a_addr, w_b_addr;
   logic [WIDTH-1:0] w_a_data, w_b_data;

   assign w_busy = (r_state == ST_SAVE) || (r_state == ST_RESTORE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      unique case (r_state)
         ST_IDLE: begin
            if (save_req) begin
               w_state_nxt = ST_SAVE;
               w_idx_nxt   = AW'(1);
            end else if (restore_req) begin
               w_state_nxt = ST_RESTORE;
               w_idx_nxt   = AW'(1);
            end
         end
         ST_SAVE, ST_RESTORE: begin
            w_idx_nxt = r_idx + AW'(1);
            if (r_idx == c_LAST) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Read slot 3 is the op source register when idle and the copy source while busy.
   assign w_lv_raddr[0] = raddr1;
   assign w_lv_raddr[1] = raddr2;
   assign w_lv_raddr[2] = c_ACC;
   assign w_lv_raddr[3] = w_busy ? r_idx : waddr;
   assign w_sh_raddr[0] = r_idx;

   always_comb begin
      w_a_we   = 1'b0;
      w_a_addr = waddr;
      w_a_data = wdata;
      w_b_we   = 1'b0;
      w_b_addr = c_ACC;
      w_b_data = wdata;
      if (r_state == ST_RESTORE) begin
         w_b_we   = 1'b1;
         w_b_addr = r_idx;
         w_b_data = w_sh_rd[0];
      end else if (!w_busy) begin
         unique case (op)
            OP_WR: begin
               w_a_we = 1'b1;
            end
            OP_WR_ACC: begin
               w_b_we = 1'b1;
            end
            OP_A2R: begin
               w_a_we   = 1'b1;
               w_a_data = w_lv_rd[2];
            end
            OP_R2A: begin
               w_b_we   = 1'b1;
               w_b_data = w_lv_rd[3];
            end
            OP_SWAP: begin
               w_a_we   = 1'b1;
               w_a_data = w_lv_rd[2];
               w_b_we   = 1'b1;
               w_b_data = w_lv_rd[3];
            end
            default: begin
               w_a_we = 1'b0;
               w_b_we = 1'b0;
            end
         endcase
      end
   end

   rf_ctx_bank #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_IDX (ZERO_IDX),
      .NRD      (4)
   ) u_live (
      .clk      (clk),
      .rst      (reset),
      .i_a_we   (w_a_we),
      .i_a_addr (w_a_addr),
      .i_a_data (w_a_data),
      .i_b_we   (w_b_we),
      .i_b_addr (w_b_addr),
      .i_b_data (w_b_data),
      .i_raddr  (w_lv_raddr),
      .o_rdata  (w_lv_rd)
   );

   rf_ctx_bank #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_IDX (ZERO_IDX),
      .NRD      (1)
   ) u_shadow (
      .clk      (clk),
      .rst      (reset),
      .i_a_we   (r_state == ST_SAVE),
      .i_a_addr (r_idx),
      .i_a_data (w_lv_rd[3]),
      .i_b_we   (1'b0),
      .i_b_addr ('0),
      .i_b_data ('0),
      .i_raddr  (w_sh_raddr),
      .o_rdata  (w_sh_rd)
   );

   assign regf_out1 = w_lv_rd[0];
   assign regf_out2 = w_lv_rd[1];
   assign acc_out   = w_lv_rd[2];
   assign busy      = w_busy;
   assign done      = (r_state == ST_DONE);
   assign op_drop   = w_busy && (op != OP_NOP);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_ctx.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_ctx
// Purpose  : directed self-checking bench for reg_file_ctx (16x8 and 8x16 builds)
// Revision : 1.0
// ============================================================================
module tb_reg_file_ctx;
   import rf_ctx_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   rf_op_e      op;
   logic [3:0]  waddr, raddr1, raddr2;
   logic [7:0]  wdata;
   logic        save_req, restore_req;
   logic [7:0]  regf_out1, regf_out2, acc_out;
   logic        busy, done, op_drop;

   rf_op_e      b_op;
   logic [2:0]  b_waddr, b_raddr1, b_raddr2;
   logic [15:0] b_wdata;
   logic        b_save_req, b_restore_req;
   logic [15:0] b_out1, b_out2, b_acc;
   logic        b_busy, b_done, b_op_drop;

   reg_file_ctx u_dut (
      .clk(clk), .reset(reset), .op(op), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .save_req(save_req), .restore_req(restore_req),
      .regf_out1(regf_out1), .regf_out2(regf_out2), .acc_out(acc_out),
      .busy(busy), .done(done), .op_drop(op_drop)
   );

   reg_file_ctx #(.WIDTH(16), .DEPTH(8)) u_dut_b (
      .clk(clk), .reset(reset), .op(b_op), .waddr(b_waddr), .wdata(b_wdata),
      .raddr1(b_raddr1), .raddr2(b_raddr2), .save_req(b_save_req), .restore_req(b_restore_req),
      .regf_out1(b_out1), .regf_out2(b_out2), .acc_out(b_acc),
      .busy(b_busy), .done(b_done), .op_drop(b_op_drop)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_a(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic wait_b(output int n);
      n = 0;
      while (b_busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic wr_a(input rf_op_e o, input logic [3:0] a, input logic [7:0] d);
      op = o; waddr = a; wdata = d;
      tick();
      op = OP_NOP;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int pulses;
      reset = 1'b1; op = OP_NOP; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      save_req = 1'b0; restore_req = 1'b0;
      b_op = OP_NOP; b_waddr = '0; b_wdata = '0; b_raddr1 = '0; b_raddr2 = '0;
      b_save_req = 1'b0; b_restore_req = 1'b0;
      tick(); tick();
      reset = 1'b0;
      raddr1 = 4'd5;
      #1;
      chk("rst_r5", regf_out1, 8'h00);
      chk("rst_acc", acc_out, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_drop", op_drop, 1'b0);

      // 1: basic write and zero-register masking
      wr_a(OP_WR, 4'd5, 8'h3C);
      wr_a(OP_WR, 4'd0, 8'hFF);
      raddr1 = 4'd5; raddr2 = 4'd0; #1;
      chk("wr_r5", regf_out1, 8'h3C);
      chk("wr_r0", regf_out2, 8'h00);

      // 2: accumulator ops
      wr_a(OP_WR_ACC, 4'd9, 8'h11);
      wr_a(OP_WR, 4'd7, 8'h22);
      wr_a(OP_SWAP, 4'd7, 8'h00);
      raddr1 = 4'd7; #1;
      chk("swap_acc", acc_out, 8'h22);
      chk("swap_r7", regf_out1, 8'h11);
      wr_a(OP_R2A, 4'd0, 8'h00);
      chk("r2a_zero", acc_out, 8'h00);
      wr_a(OP_WR_ACC, 4'd0, 8'h5A);
      wr_a(OP_A2R, 4'd9, 8'h00);
      raddr1 = 4'd9; #1;
      chk("a2r_r9", regf_out1, 8'h5A);
      wr_a(OP_R2A, 4'd7, 8'h00);
      chk("r2a_r7", acc_out, 8'h11);

      // 3: save / overwrite / restore round trip
      for (int i = 1; i < 16; i++) wr_a(OP_WR, 4'(i), 8'(i * 3));
      save_req = 1'b1; tick(); save_req = 1'b0;
      wait_a(n);
      chk("save_busy_cycles", n, 15);
      chk("save_done", done, 1'b1);
      tick();
      chk("save_done_clr", done, 1'b0);
      for (int i = 1; i < 16; i++) wr_a(OP_WR, 4'(i), 8'hAA);
      raddr1 = 4'd4; #1;
      chk("overwrite_r4", regf_out1, 8'hAA);
      restore_req = 1'b1; tick(); restore_req = 1'b0;

      // 4: op dropped and save ignored while restoring
      op = OP_WR; waddr = 4'd4; wdata = 8'h77; save_req = 1'b1; #1;
      chk("busy_drop", op_drop, 1'b1);
      chk("restore_busy", busy, 1'b1);
      tick();
      op = OP_NOP; save_req = 1'b0;
      wait_a(n);
      chk("restore_busy_cycles", n + 1, 15);
      chk("restore_done", done, 1'b1);
      tick();
      chk("save_ignored", busy, 1'b0);
      for (int i = 1; i < 16; i++) begin
         raddr1 = 4'(i); #1;
         chk($sformatf("restored_r%0d", i), regf_out1, 8'(i * 3));
      end

      // 5: save priority, then reset mid-save
      wr_a(OP_WR, 4'd3, 8'h99);
      save_req = 1'b1; restore_req = 1'b1; tick();
      save_req = 1'b0; restore_req = 1'b0;
      wait_a(n);
      raddr1 = 4'd3; #1;
      chk("both_req_save_wins", regf_out1, 8'h99);
      tick();
      save_req = 1'b1; tick(); save_req = 1'b0;
      repeat (5) tick();
      chk("mid_save_busy", busy, 1'b1);
      reset = 1'b1; tick(); reset = 1'b0;
      raddr1 = 4'd3; #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_r3", regf_out1, 8'h00);
      chk("abort_acc", acc_out, 8'h00);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) pulses++;
         tick();
      end
      chk("abort_no_done", pulses, 0);
      wr_a(OP_WR, 4'd3, 8'h55);
      restore_req = 1'b1; tick(); restore_req = 1'b0;
      wait_a(n);
      raddr1 = 4'd3; #1;
      chk("shadow_cleared", regf_out1, 8'h00);

      // 6: 8-deep, 16-bit build
      for (int i = 1; i < 8; i++) begin
         b_op = OP_WR; b_waddr = 3'(i); b_wdata = 16'h1000 + 16'(i * 16'h0111);
         tick();
      end
      b_op = OP_NOP;
      b_save_req = 1'b1; tick(); b_save_req = 1'b0;
      wait_b(n);
      chk("b_save_busy_cycles", n, 7);
      chk("b_save_done", b_done, 1'b1);
      tick();
      for (int i = 1; i < 8; i++) begin
         b_op = OP_WR; b_waddr = 3'(i); b_wdata = 16'h0000;
         tick();
      end
      b_op = OP_NOP;
      b_raddr1 = 3'd7; #1;
      chk("b_overwrite_r7", b_out1, 16'h0000);
      b_restore_req = 1'b1; tick(); b_restore_req = 1'b0;
      wait_b(n);
      chk("b_restore_busy_cycles", n, 7);
      tick();
      for (int i = 1; i < 8; i++) begin
         b_raddr2 = 3'(i); #1;
         chk($sformatf("b_restored_r%0d", i), b_out2, 16'h1000 + 16'(i * 16'h0111));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
